// File: rtl/lsu_ctrl.sv
// lsu_ctrl: non-pipelined load/store control stage between EXU and memory.
// One request in flight: accept, check, single-cycle strobe, wait for read
// data, extend, then hold the result until WBU takes it.
//
// Handshakes: a transfer happens on a posedge where valid & ready are both
// high. in_ready is high only in IDLE. out_valid is high only in RESP, and
// out_data/out_rd/out_err stay stable until out_valid & out_ready.
module lsu_ctrl #(
    parameter int              XLEN     = 64,
    parameter int              RD_LAT   = 1,
    parameter logic [XLEN-1:0] RAM_BASE = 64'h8000_0000,
    parameter logic [XLEN-1:0] RAM_SIZE = 64'h0800_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_ren,
    input  logic            in_wen,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [4:0]      in_rd,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_raddr,
    output logic [XLEN-1:0] mem_waddr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [1:0]      mem_size,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic [1:0]      out_err,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int              CW      = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [XLEN-1:0] RAM_TOP = RAM_BASE + RAM_SIZE;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_FAULT = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    state_t          state;
    state_t          state_nxt;

    logic            ren_q;
    logic            wen_q;
    logic            uns_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic [1:0]      err_q;
    logic [XLEN-1:0] data_q;
    logic [CW-1:0]   cnt_q;

    logic            accept;
    logic            misalign;
    logic            in_window;
    logic [1:0]      req_err;

    // Sign/zero-extend the access width; bits above the width are discarded.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                               input logic [1:0]      sz,
                                               input logic            uns);
        logic [XLEN-1:0] r;
        case (sz)
            2'b00:   r = {{(XLEN-8){~uns & d[7]}}, d[7:0]};
            2'b01:   r = {{(XLEN-16){~uns & d[15]}}, d[15:0]};
            2'b10:   r = {{(XLEN-32){~uns & d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept = in_valid & in_ready;

    // Request checks in priority order: illegal, misaligned, out of window.
    always_comb begin
        misalign  = 1'b0;
        in_window = (in_addr >= RAM_BASE) && (in_addr < RAM_TOP);
        req_err   = ERR_OK;
        case (in_size)
            2'b01:   misalign = in_addr[0];
            2'b10:   misalign = |in_addr[1:0];
            2'b11:   misalign = |in_addr[2:0];
            default: misalign = 1'b0;
        endcase
        if (in_ren && in_wen) begin
            req_err = ERR_ILL;
        end else if (misalign) begin
            req_err = ERR_ALIGN;
        end else if ((in_ren || in_wen) && !in_window) begin
            req_err = ERR_FAULT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err != ERR_OK || (!in_ren && !in_wen)) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_ACCESS;
                    end
                end
            end
            S_ACCESS: state_nxt = wen_q ? S_RESP : S_WAIT;
            S_WAIT:   state_nxt = (cnt_q == CW'(1)) ? S_RESP : S_WAIT;
            S_RESP:   state_nxt = out_ready ? S_IDLE : S_RESP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request latch, latency counter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
            err_q   <= ERR_OK;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ren_q   <= in_ren;
                        wen_q   <= in_wen;
                        uns_q   <= in_unsigned;
                        size_q  <= in_size;
                        addr_q  <= in_addr;
                        wdata_q <= in_wdata;
                        rd_q    <= in_rd;
                        err_q   <= req_err;
                        if (req_err != ERR_OK) begin
                            data_q <= '0;
                        end else if (!in_ren && !in_wen) begin
                            data_q <= in_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (wen_q) begin
                        data_q <= '0;
                    end else begin
                        cnt_q <= CW'(RD_LAT);
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        data_q <= extend(mem_rdata, size_q, uns_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from state so they drop as soon as reset asserts.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_RESP);
    assign mem_ren   = (state == S_ACCESS) & ren_q;
    assign mem_wen   = (state == S_ACCESS) & wen_q;
    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign out_data  = data_q;
    assign out_rd    = rd_q;
    assign out_err   = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small memory model and strobe counters.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_ren;
    logic        in_wen;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic        mem_ren;
    logic        mem_wen;
    logic [63:0] mem_raddr;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [63:0] mem_rdata = 64'd0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [1:0]  out_err;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int ren_cnt = 0;
    int wen_cnt = 0;

    logic [63:0] mem [logic [63:0]];
    logic [63:0] fill = 64'd0;

    lsu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ren      (in_ren),
        .in_wen      (in_wen),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_size     (in_size),
        .in_unsigned (in_unsigned),
        .in_rd       (in_rd),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_raddr   (mem_raddr),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_size    (mem_size),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_err     (out_err),
        .state_dbg   (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory model: registered read data one cycle after the strobe edge.
    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_waddr] = mem_wdata;
            wen_cnt++;
        end
        if (mem_ren) begin
            mem_rdata <= mem.exists(mem_raddr) ? mem[mem_raddr] : fill;
            ren_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request and release in_valid right after the accept edge.
    task automatic drive(input logic ren, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd);
        @(negedge clk);
        in_ren      = ren;
        in_wen      = wen;
        in_addr     = addr;
        in_wdata    = wdata;
        in_size     = size;
        in_unsigned = uns;
        in_rd       = rd;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Full request: drive, measure latency, check result, optionally stall RESP.
    task automatic run_req(input string tag, input logic ren, input logic wen,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [1:0] size, input logic uns, input logic [4:0] rd,
                           input logic [63:0] exp_data, input logic [1:0] exp_err,
                           input int exp_lat, input int exp_rp, input int exp_wp,
                           input int hold);
        int lat;
        int r0;
        int w0;
        r0 = ren_cnt;
        w0 = wen_cnt;
        out_ready = (hold == 0);
        drive(ren, wen, addr, wdata, size, uns, rd);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_err"}, 64'(out_err), 64'(exp_err));
        check({tag, "_rd"}, 64'(out_rd), 64'(rd));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_ren   = 1'b1;
            in_addr  = 64'h8000_0100;
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_data"}, out_data, exp_data);
            check({tag, "_hold_rd"}, 64'(out_rd), 64'(rd));
            check({tag, "_hold_inrdy"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_done_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_done_inrdy"}, 64'(in_ready), 64'd1);
        check({tag, "_ren_pulses"}, 64'(ren_cnt - r0), 64'(exp_rp));
        check({tag, "_wen_pulses"}, 64'(wen_cnt - w0), 64'(exp_wp));
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_ren      = 1'b0;
        in_wen      = 1'b0;
        in_addr     = 64'd0;
        in_wdata    = 64'd0;
        in_size     = 2'b00;
        in_unsigned = 1'b0;
        in_rd       = 5'd0;
        out_ready   = 1'b1;

        // Reset values.
        #12;
        check("rst_inrdy", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ren", 64'(mem_ren), 64'd0);
        check("rst_wen", 64'(mem_wen), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_rd", 64'(out_rd), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_raddr", mem_raddr, 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed byte load.
        fill = 64'h80;
        run_req("lb", 1, 0, 64'h8000_0003, 0, 2'b00, 0, 5'd3,
                64'hFFFF_FFFF_FFFF_FF80, 2'b00, 3, 1, 0, 0);
        // Misaligned halfword: no strobe, one-cycle error.
        run_req("lhu_mis", 1, 0, 64'h8000_0001, 0, 2'b01, 1, 5'd4,
                64'd0, 2'b01, 1, 0, 0, 0);
        // Store then load back through the memory model.
        run_req("sd", 0, 1, 64'h8000_0010, 64'h1122_3344_5566_7788, 2'b11, 0, 5'd5,
                64'd0, 2'b00, 2, 0, 1, 0);
        check("sd_waddr", mem_waddr, 64'h8000_0010);
        check("sd_wdata", mem_wdata, 64'h1122_3344_5566_7788);
        check("sd_size", 64'(mem_size), 64'd3);
        run_req("ld", 1, 0, 64'h8000_0010, 0, 2'b11, 0, 5'd6,
                64'h1122_3344_5566_7788, 2'b00, 3, 1, 0, 0);

        // Extension with garbage above the access width.
        fill = 64'hDEAD_BEEF_8000_0001;
        run_req("lw", 1, 0, 64'h8000_0020, 0, 2'b10, 0, 5'd7,
                64'hFFFF_FFFF_8000_0001, 2'b00, 3, 1, 0, 0);
        run_req("lwu", 1, 0, 64'h8000_0020, 0, 2'b10, 1, 5'd8,
                64'h0000_0000_8000_0001, 2'b00, 3, 1, 0, 0);
        fill = 64'hFFFF_FFFF_FFFF_FF80;
        run_req("lbu", 1, 0, 64'h8000_0007, 0, 2'b00, 1, 5'd9,
                64'h0000_0000_0000_0080, 2'b00, 3, 1, 0, 0);
        fill = 64'h0000_0000_0001_8001;
        run_req("lh", 1, 0, 64'h8000_0002, 0, 2'b01, 0, 5'd10,
                64'hFFFF_FFFF_FFFF_8001, 2'b00, 3, 1, 0, 0);
        run_req("lhu", 1, 0, 64'h8000_0002, 0, 2'b01, 1, 5'd11,
                64'h0000_0000_0000_8001, 2'b00, 3, 1, 0, 0);

        // Pass-through.
        run_req("pass", 0, 0, 64'h0, 64'hCAFE, 2'b00, 0, 5'd12,
                64'hCAFE, 2'b00, 1, 0, 0, 0);

        // Window edges, illegal combination, check priority.
        run_req("ld_below", 1, 0, 64'h7FFF_FFF8, 0, 2'b11, 0, 5'd13,
                64'd0, 2'b10, 1, 0, 0, 0);
        run_req("ld_above", 1, 0, 64'h8800_0000, 0, 2'b11, 0, 5'd14,
                64'd0, 2'b10, 1, 0, 0, 0);
        fill = 64'h0123_4567_89AB_CDEF;
        run_req("ld_top", 1, 0, 64'h87FF_FFF8, 0, 2'b11, 0, 5'd15,
                64'h0123_4567_89AB_CDEF, 2'b00, 3, 1, 0, 0);
        run_req("sd_above", 0, 1, 64'h8800_0000, 64'h55, 2'b11, 0, 5'd16,
                64'd0, 2'b10, 1, 0, 0, 0);
        run_req("ill", 1, 1, 64'h8000_0001, 64'h55, 2'b01, 0, 5'd17,
                64'd0, 2'b11, 1, 0, 0, 0);
        run_req("mis_prio", 1, 0, 64'h7FFF_FFFF, 0, 2'b01, 0, 5'd18,
                64'd0, 2'b01, 1, 0, 0, 0);

        // WBU back-pressure for three cycles.
        fill = 64'h0000_0000_8765_4321;
        run_req("lw_stall", 1, 0, 64'h8000_0040, 0, 2'b10, 0, 5'd19,
                64'hFFFF_FFFF_8765_4321, 2'b00, 3, 1, 0, 3);

        // Reset while the read strobe is up: it must drop without a clock edge.
        drive(1, 0, 64'h8000_0010, 0, 2'b11, 0, 5'd20);
        check("rstA_ren_pre", 64'(mem_ren), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstA_ren", 64'(mem_ren), 64'd0);
        check("rstA_inrdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while waiting for read data.
        drive(1, 0, 64'h8000_0010, 0, 2'b11, 0, 5'd21);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstW_ren", 64'(mem_ren), 64'd0);
        check("rstW_valid", 64'(out_valid), 64'd0);
        check("rstW_inrdy", 64'(in_ready), 64'd1);
        check("rstW_data", out_data, 64'd0);
        check("rstW_raddr", mem_raddr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req("ld_after_rst", 1, 0, 64'h8000_0010, 0, 2'b11, 0, 5'd22,
                64'h1122_3344_5566_7788, 2'b00, 3, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
